// File: rtl/operand_mux_ctrl.sv
// Operand-select mux sequencer for the SISC 16-bit ALU: decodes the operand class, captures Rs, holds sel, reports done/err.
// Optional abort input is compiled in when OPMUX_ABORT_EN is defined.
module operand_mux_ctrl #(
    parameter int unsigned RS_WAIT_MAX = 4,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_f,
    input  logic       start,
    input  logic [1:0] op_class,
    input  logic       rs_valid,
`ifdef OPMUX_ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] sel,
    output logic       rs_new,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RS_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       SEL_RS    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RS,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             abort_c;

`ifdef OPMUX_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Shared wait/hold counter saturates instead of wrapping
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel     <= 2'd0;
            rs_new  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rs_new <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            // Abort drops straight to IDLE without a done/err pulse; sel is left alone
            if (abort_c && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            busy  <= 1'b1;
                            cnt_q <= '0;
                            case (op_class)
                                2'd0, 2'd1: begin
                                    state_q <= ST_HOLD;
                                    sel     <= op_class;
                                end
                                2'd2: begin
                                    state_q <= ST_WAIT_RS;
                                end
                                default: begin
                                    state_q <= ST_DONE;
                                    done    <= 1'b1;
                                    err     <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_WAIT_RS: begin
                        // rs_valid wins over a timeout in the same cycle
                        if (rs_valid) begin
                            state_q <= ST_CAPTURE;
                            rs_new  <= 1'b1;
                            cnt_q   <= '0;
                        end else if (cnt_q == WAIT_LAST) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_CAPTURE: begin
                        // sel moves to the held Rs only after the capture strobe
                        state_q <= ST_HOLD;
                        sel     <= SEL_RS;
                        cnt_q   <= '0;
                    end
                    ST_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
